penalty_marker_gen: RTL and testbench

Parametrised penalty-marker renderer for the OLED pixel pipeline. It keeps its own saturating penalty counter, driven by increment and clear pulses from game logic, and asserts a registered `print_black` for every pixel inside one of the active markers. Markers are stacked vertically. The newest marker blinks after each accepted penalty. The block sits between game-state logic and the OLED colour mux, in parallel with the other overlay generators.

---
 rtl/penalty_marker_gen.sv | 138 +++++++++++++
 tb/tb_penalty_marker_gen.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/penalty_marker_gen.sv
// Penalty counter and stacked marker overlay for the OLED pixel pipeline.
// Optional blink of the newest marker is compiled in with PEN_BLINK_EN.
module penalty_marker_gen #(
  parameter int MAX_PEN       = 3,
  parameter int MARK_W        = 2,
  parameter int MARK_H        = 2,
  parameter int PITCH         = 5,
  parameter int COORD_W       = 8,
  parameter int BLINK_CYC     = 3125000,
  parameter int BLINK_TOGGLES = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pen_inc,
  input  logic               pen_clr,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] x_start,
  input  logic [COORD_W-1:0] y_start,
  output logic               print_black,
  output logic [3:0]         pen_count,
  output logic               pen_full,
  output logic               blink_active
);

  localparam int EW = COORD_W + 4;

  logic       accept;
  logic       blink_hide;
  logic [3:0] blink_idx;

  assign pen_full = (pen_count == 4'(MAX_PEN));
  assign accept   = pen_inc && !pen_clr &&
                    (pen_count < 4'(MAX_PEN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pen_count <= 4'd0;
    end else if (pen_clr) begin
      pen_count <= 4'd0;
    end else if (accept) begin
      pen_count <= pen_count + 4'd1;
    end
  end

`ifdef PEN_BLINK_EN
  localparam int CW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam int HW = $clog2(BLINK_TOGGLES);

  typedef enum logic [1:0] {IDLE, SHOW, HIDE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cyc_q, cyc_nx;
  logic [HW-1:0] half_q, half_nx;
  logic [3:0]    idx_q, idx_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cyc_q  <= '0;
      half_q <= '0;
      idx_q  <= '0;
    end else begin
      state  <= state_nx;
      cyc_q  <= cyc_nx;
      half_q <= half_nx;
      idx_q  <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cyc_nx   = cyc_q;
    half_nx  = half_q;
    idx_nx   = idx_q;
    if (pen_clr) begin
      state_nx = IDLE;
      cyc_nx   = '0;
      half_nx  = '0;
    end else if (accept) begin
      state_nx = HIDE;
      cyc_nx   = '0;
      half_nx  = '0;
      idx_nx   = pen_count;
    end else if (state != IDLE) begin
      if (cyc_q == CW'(BLINK_CYC - 1)) begin
        cyc_nx = '0;
        if (half_q == HW'(BLINK_TOGGLES - 1)) begin
          state_nx = IDLE;
          half_nx  = '0;
        end else begin
          half_nx  = half_q + 1'b1;
          state_nx = (state == HIDE) ? SHOW : HIDE;
        end
      end else begin
        cyc_nx = cyc_q + 1'b1;
      end
    end
  end

  assign blink_hide   = (state == HIDE);
  assign blink_idx    = idx_q;
  assign blink_active = (state != IDLE);
`else
  assign blink_hide   = 1'b0;
  assign blink_idx    = 4'd0;
  assign blink_active = 1'b0;
`endif

  // Widened coordinates so marker extents past the screen edge never wrap.
  logic [EW-1:0]      xe, ye, xs, ys;
  logic               x_hit;
  logic [MAX_PEN-1:0] slot_hit;

  assign xe    = EW'(x);
  assign ye    = EW'(y);
  assign xs    = EW'(x_start);
  assign ys    = EW'(y_start);
  assign x_hit = (xe >= xs) && (xe <= xs + EW'(MARK_W - 1));

  for (genvar g = 0; g < MAX_PEN; g++) begin : g_slot
    logic [EW-1:0] top;
    assign top = ys + EW'(g * PITCH);
    assign slot_hit[g] = (pen_count > 4'(g)) &&
                         (ye >= top) &&
                         (ye <= top + EW'(MARK_H - 1)) &&
                         !(blink_hide && blink_idx == 4'(g));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      print_black <= 1'b0;
    end else begin
      print_black <= x_hit && (|slot_hit);
    end
  end

endmodule

// File: tb/tb_penalty_marker_gen.sv
// Randomised and directed bench for penalty_marker_gen.
// Reference model tracks count, blink age and marker rectangles directly.
module tb_penalty_marker_gen;

  localparam int MAX_PEN = 3;
  localparam int MARK_W  = 2;
  localparam int MARK_H  = 2;
  localparam int PITCH   = 5;
  localparam int CW      = 8;
  localparam int BC      = 4;
  localparam int BT      = 2;
`ifdef PEN_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pen_inc, pen_clr;
  logic [CW-1:0] x, y, x_start, y_start;
  logic          print_black;
  logic [3:0]    pen_count;
  logic          pen_full;
  logic          blink_active;

  penalty_marker_gen #(
    .MAX_PEN(MAX_PEN), .MARK_W(MARK_W), .MARK_H(MARK_H),
    .PITCH(PITCH), .COORD_W(CW),
    .BLINK_CYC(BC), .BLINK_TOGGLES(BT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pen_inc(pen_inc), .pen_clr(pen_clr),
    .x(x), .y(y), .x_start(x_start), .y_start(y_start),
    .print_black(print_black), .pen_count(pen_count),
    .pen_full(pen_full), .blink_active(blink_active)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // model state
  int m_cnt;
  int m_idx;
  bit m_act;
  int m_age;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic bit m_hidden();
    return m_act && ((m_age / BC) % 2 == 0);
  endfunction

  function automatic bit m_hit(input int xx, input int yy);
    int xs, ys, top;
    xs = int'(x_start);
    ys = int'(y_start);
    if (xx < xs || xx > xs + MARK_W - 1) return 1'b0;
    for (int i = 0; i < m_cnt; i++) begin
      top = ys + i * PITCH;
      if (yy >= top && yy <= top + MARK_H - 1 &&
          !(m_hidden() && i == m_idx))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic m_reset();
    m_cnt = 0;
    m_idx = 0;
    m_act = 1'b0;
    m_age = 0;
  endtask

  // One clock: drive inputs, predict, clock, compare.
  task automatic cycle(input bit inc, input bit clr,
                       input int xx, input int yy);
    bit exp_pb;
    pen_inc = inc;
    pen_clr = clr;
    x = CW'(xx);
    y = CW'(yy);
    exp_pb = m_hit(xx, yy);
    if (clr) begin
      m_cnt = 0;
      m_act = 1'b0;
      m_age = 0;
    end else if (inc && m_cnt < MAX_PEN) begin
      m_idx = m_cnt;
      m_cnt++;
      m_act = BLINK_EN;
      m_age = 0;
    end else if (m_act) begin
      m_age++;
      if (m_age >= BC * BT) m_act = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("pen_count", 32'(pen_count), 32'(m_cnt));
    chk("pen_full", 32'(pen_full), 32'(m_cnt == MAX_PEN));
    chk("blink_active", 32'(blink_active), 32'(m_act));
    chk($sformatf("print_black(%0d,%0d)", xx, yy),
        32'(print_black), 32'(exp_pb));
  endtask

  initial begin
    rst_n   = 1'b0;
    pen_inc = 1'b0;
    pen_clr = 1'b0;
    x       = '0;
    y       = '0;
    x_start = 8'd10;
    y_start = 8'd20;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(pen_count), 0);
    chk("rst_full", 32'(pen_full), 0);
    chk("rst_blink", 32'(blink_active), 0);
    chk("rst_pb", 32'(print_black), 0);
    rst_n = 1'b1;

    // single penalty, watch marker 0 blink
    cycle(1, 0, 10, 20);
    repeat (12) cycle(0, 0, 10, 20);
    cycle(1, 1, 10, 20);
    cycle(1, 0, 12, 20);
    repeat (10) cycle(0, 0, 12, 20);

    // three penalties then vertical scan
    cycle(0, 1, 11, 20);
    for (int n = 0; n < 3; n++) begin
      cycle(1, 0, 11, 20);
      repeat (19) cycle(0, 0, 11, 20);
    end
    for (int yy = 20; yy <= 34; yy++) cycle(0, 0, 11, yy);
    cycle(1, 0, 11, 30);
    repeat (3) cycle(0, 0, 11, 30);

    // simultaneous inc+clr at count 2
    cycle(0, 1, 10, 20);
    cycle(1, 0, 10, 20);
    repeat (10) cycle(0, 0, 10, 20);
    cycle(1, 0, 10, 25);
    repeat (10) cycle(0, 0, 10, 25);
    cycle(1, 1, 10, 20);
    for (int yy = 20; yy <= 26; yy++) cycle(0, 0, 10, yy);

    // restart blink two cycles in
    cycle(1, 0, 10, 20);
    cycle(0, 0, 10, 20);
    cycle(1, 0, 10, 20);
    for (int k = 0; k < 12; k++) begin
      cycle(0, 0, 10, 20);
      cycle(0, 0, 10, 25);
    end

    // overflow past bottom edge must not wrap to row 0
    cycle(0, 1, 10, 0);
    y_start = 8'd250;
    for (int n = 0; n < 3; n++) begin
      cycle(1, 0, 10, 0);
      repeat (9) cycle(0, 0, 11, 0);
    end
    for (int yy = 0; yy <= 5; yy++) begin
      cycle(0, 0, 10, yy);
      cycle(0, 0, 11, yy);
    end
    cycle(0, 0, 10, 251);
    cycle(0, 0, 10, 255);

    // asynchronous reset in the middle of a blink
    y_start = 8'd20;
    cycle(0, 1, 10, 20);
    cycle(1, 0, 10, 20);
    repeat (10) cycle(0, 0, 10, 20);
    cycle(1, 0, 10, 20);
    cycle(0, 0, 10, 20);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(pen_count), 0);
    chk("arst_full", 32'(pen_full), 0);
    chk("arst_blink", 32'(blink_active), 0);
    chk("arst_pb", 32'(print_black), 0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 0, 10, 20);
    repeat (3) cycle(0, 0, 10, 20);

    // random traffic
    for (int k = 0; k < 600; k++) begin
      int xx, yy;
      bit inc, clr;
      inc = ($urandom_range(0, 5) == 0);
      clr = ($urandom_range(0, 39) == 0);
      xx  = $urandom_range(8, 13);
      yy  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255)
                                        : $urandom_range(18, 33);
      cycle(inc, clr, xx, yy);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
